// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // One buffered instruction: the fetch address it came from plus the fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ifq_entry_t;

  localparam int ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ifq_if.sv
// Bundle of the pc, imem and decode-side signals around the fetch queue.
interface ifq_if;
  // imem: transfer when imem_req && imem_gnt; req/addr hold until granted.
  // Responses come back in order on imem_rvalid with no backpressure.
  // Decode: transfer when inst_valid && inst_ready.
  logic [31:0] pc_addr;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport slave (
    input  pc_addr, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output pc_en, imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport master (
    output pc_addr, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  pc_en, imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with clear; any depth >= 1 (pointers wrap explicitly).
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    wr_q  <= wr_d;
    cnt_q <= cnt_d;
    if (do_push && !clr) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues imem requests, buffers responses, drops stale ones after flush.
// Optional IFQ_BYPASS_EN presents a response on inst_* in its rvalid cycle when the buffer is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  ifq_if.slave        bus,
  output ifq_state_e  dbg_state
);
  localparam int OCW = $clog2(DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTST + 1);
  localparam int SW  = OCW + 1;

  ifq_state_e     state_q, state_d;
  logic [TCW-1:0] discard_q, discard_d;

  logic           tag_push, tag_pop, tag_full, tag_empty;
  logic [31:0]    tag_pc;
  logic [TCW-1:0] tag_count;

  logic           inst_push, inst_pop, inst_full, inst_empty, inst_clr;
  logic [OCW-1:0] inst_count;
  ifq_entry_t     inst_wdata, inst_head;

  logic [SW-1:0]  in_use;
  logic           run_live, issue, grant, resp_ok, bypass;
  logic [TCW-1:0] out_after;

  // The tag FIFO occupancy is the outstanding-request count.
  ifq_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .clr   (!rst),
    .push  (tag_push),
    .pop   (tag_pop),
    .wdata (bus.pc_addr),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  ifq_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_inst_fifo (
    .clk   (clk),
    .clr   (inst_clr),
    .push  (inst_push),
    .pop   (inst_pop),
    .wdata (inst_wdata),
    .rdata (inst_head),
    .full  (inst_full),
    .empty (inst_empty),
    .count (inst_count)
  );

  always_comb begin
    run_live  = rst && (state_q == RUN) && !bus.flush;
    in_use    = SW'(inst_count) + SW'(tag_count);
    // Every in-flight request has a reserved buffer slot, so a response never finds it full.
    issue     = run_live && (in_use < SW'(DEPTH)) && !tag_full && !inst_full;
    grant     = issue && bus.imem_gnt;
    resp_ok   = rst && bus.imem_rvalid && !tag_empty;
    out_after = tag_count + TCW'(grant) - TCW'(resp_ok);
`ifdef IFQ_BYPASS_EN
    bypass    = run_live && resp_ok && inst_empty;
`else
    bypass    = 1'b0;
`endif
    tag_push  = grant;
    tag_pop   = resp_ok;

    inst_clr        = !rst || bus.flush;
    inst_wdata.pc   = tag_pc;
    inst_wdata.data = bus.imem_rdata;
    inst_push       = run_live && resp_ok && !(bypass && bus.inst_ready);

    bus.imem_req   = issue;
    bus.imem_addr  = issue ? bus.pc_addr : 32'h0;
    bus.pc_en      = grant;
    bus.inst_valid = rst && !bus.flush && (bypass || !inst_empty);
    inst_pop       = bus.inst_valid && bus.inst_ready && !bypass;
    bus.inst_data  = 32'h0;
    bus.inst_pc    = 32'h0;
    if (bypass) begin
      bus.inst_data = bus.imem_rdata;
      bus.inst_pc   = tag_pc;
    end else if (bus.inst_valid) begin
      bus.inst_data = inst_head.data;
      bus.inst_pc   = inst_head.pc;
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    case (state_q)
      RUN: begin
        if (bus.flush) begin
          discard_d = out_after;
          if (out_after != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A repeated flush here only re-clears the buffer; stale responses still need dropping.
        if (resp_ok && (discard_q != '0)) discard_d = discard_q - TCW'(1);
        if (discard_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_OUTST, default 2, meaning the maximum number of in-flight imem requests (1..3).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port pc_addr, input, 32 bits: current fetch address from the pc block.
REQ-006 SHALL have port pc_en, output, 1 bit: pc block advances by 4 in the cycle this is high.
REQ-007 SHALL have port flush, input, 1 bit: redirect (set_en, jal or branch taken); pc_addr holds the new target next cycle.
REQ-008 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_gnt (input, 1): request channel; transfer when req&&gnt.
REQ-009 SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 32): in-order response channel, no backpressure.
REQ-010 SHALL have ports inst_valid (output, 1), inst_data (output, 32), inst_pc (output, 32), inst_ready (input, 1): decode-side valid/ready.

Function
REQ-011 SHALL drive imem_addr=pc_addr and imem_req=1 in state RUN when occupancy+outstanding<DEPTH and outstanding<MAX_OUTST and flush=0.
REQ-012 SHALL assert pc_en exactly in cycles where imem_req&&imem_gnt; imem_req SHALL hold stable with constant address until granted unless flush.
REQ-013 SHALL push each issued address into an address tag FIFO (depth MAX_OUTST), and pair it with imem_rdata on rvalid.
REQ-014 SHALL write {tag pc, rdata} into the instruction FIFO on rvalid when discard count is 0; the FIFO head drives inst_pc/inst_data, inst_valid=!empty.
REQ-015 SHALL pop the FIFO head on inst_valid&&inst_ready; simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-016 SHALL implement a 2-state FSM: RUN, DRAIN; RUN->DRAIN on flush when outstanding (after this cycle's events) >0; RUN stays RUN on flush when 0; DRAIN->RUN when discard count reaches 0.
REQ-017 SHALL, on flush: empty the instruction FIFO, set discard count = outstanding including any grant that cycle, deassert imem_req and pc_en that cycle.
REQ-018 SHALL, in DRAIN, drop each rvalid (decrementing discard count) and issue no requests; flush in DRAIN SHALL re-clear the FIFO and keep the count.
REQ-019 SHALL keep the outstanding counter = grants - responses; it SHALL never exceed MAX_OUTST nor go below 0 (rvalid with outstanding=0 ignored).
REQ-020 SHALL deliver instructions in address-issue order with latency: grant -> rvalid -> inst_valid next cycle (see REQ-025).
REQ-021 SHALL drive inst_valid=0 in the same cycle flush=1.

Reset
REQ-022 SHALL, when rst=0 at a clock edge: FSM=RUN, FIFOs empty, outstanding=0, discard=0.
REQ-023 SHALL hold outputs reset values: imem_req=0, pc_en=0, inst_valid=0, imem_addr=0, inst_data=0, inst_pc=0; first request no earlier than the cycle after rst rises.
REQ-024 SHALL treat reset mid-transaction as flush-with-forget: later rvalids for pre-reset requests are the system's responsibility (imem reset together).

Configuration
REQ-025 SHALL, with macro IFQ_BYPASS_EN defined, present imem_rdata/tag combinationally on inst_* when the FIFO is empty, rvalid=1, state RUN, flush=0 (zero-cycle latency; consumed without a write if inst_ready=1, otherwise written).
REQ-026 SHALL, without IFQ_BYPASS_EN, always route responses through the FIFO (one-cycle latency, registered inst_* path).

Structure
REQ-027 SHALL place FSM state encoding (RUN, DRAIN), NOP constant 32'h00000013 and the instruction FIFO entry width in shared package ifq_pkg.
REQ-028 SHALL use one sub-module ifq_fifo (parameterised width/depth, sync clear, push/pop/full/empty/count), instantiated for both the tag FIFO and the instruction FIFO.

Verification
REQ-029 SHALL cover streaming: gnt=1, rvalid 1 cycle after grant, ready=1, pc 0x0 -> inst_pc 0x0,0x4,0x8 on consecutive cycles, pc_en high every cycle.
REQ-030 SHALL cover backpressure: ready=0 for 10 cycles with DEPTH=4 -> exactly 4 grants, imem_req low after that, no loss when ready returns.
REQ-031 SHALL cover flush with 2 outstanding: flush at pc 0x10 then target 0x100 -> the 2 stale rvalids are dropped and the first inst_pc is 0x100.
REQ-032 SHALL cover simultaneous flush and grant in one cycle -> discard count includes that grant and pc_en=0.
REQ-033 SHALL cover reset during DRAIN -> all outputs 0 next cycle and a fresh fetch from pc_addr after rst=1.
REQ-034 SHALL cover bypass on/off: same stimulus -> inst_valid in the rvalid cycle with IFQ_BYPASS_EN, one cycle later without.
